sync_generator: RTL

- Programmable video timing generator: produces hsync, vsync and data-enable (de) plus pixel/line positions from one pixel clock.
- Transmit-side counterpart of the sync measurement logic in the sync core. Its outputs feed the HDMI TX path and can be looped back into the frame measurement block for self-test.
- Timing is runtime-programmable through porch/pulse widths. Configuration is shadowed and applied only at frame boundaries.

---
 rtl/sync_generator.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/sync_generator.sv
// Programmable video timing generator: hsync/vsync/de plus hpos/vpos from one pixel clock.
// Define SYNC_GEN_PATTERN_EN to add the rgb colour-bar test pattern output.
module sync_generator #(
   parameter bit HSYNC_POL = 1'b1,
   parameter bit VSYNC_POL = 1'b1,
   parameter int CW        = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [CW-1:0] h_active,
   input  logic [CW-1:0] h_fp,
   input  logic [CW-1:0] h_sync,
   input  logic [CW-1:0] h_bp,
   input  logic [CW-1:0] v_active,
   input  logic [CW-1:0] v_fp,
   input  logic [CW-1:0] v_sync,
   input  logic [CW-1:0] v_bp,
   output logic          hsync,
   output logic          vsync,
   output logic          de,
   output logic [CW-1:0] hpos,
   output logic [CW-1:0] vpos,
   output logic          frame_start,
   output logic          cfg_err
`ifdef SYNC_GEN_PATTERN_EN
   ,
   output logic [23:0]   rgb
`endif
);

   localparam int TW = CW + 2;

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
   state_t state;

   // Shadow copy of the timing, held as the decode boundaries actually used.
   logic [CW-1:0] ha_s, hss_s, hse_s, h_last_s;
   logic [CW-1:0] va_s, vss_s, vse_s, v_last_s;

   logic [TW-1:0] h_hs_start_w, h_hs_end_w, h_total_w;
   logic [TW-1:0] v_vs_start_w, v_vs_end_w, v_total_w;
   logic [CW-1:0] h_last_in, v_last_in;
   logic          in_valid;

   always_comb begin
      h_hs_start_w = TW'(h_active) + TW'(h_fp);
      h_hs_end_w   = h_hs_start_w + TW'(h_sync);
      h_total_w    = h_hs_end_w + TW'(h_bp);
      v_vs_start_w = TW'(v_active) + TW'(v_fp);
      v_vs_end_w   = v_vs_start_w + TW'(v_sync);
      v_total_w    = v_vs_end_w + TW'(v_bp);
      h_last_in    = h_total_w[CW-1:0] - CW'(1);
      v_last_in    = v_total_w[CW-1:0] - CW'(1);
      // Partial sums never exceed the total; checking them too keeps every bit meaningful.
      in_valid = (h_hs_start_w[TW-1:CW] == '0) && (h_hs_end_w[TW-1:CW] == '0)
              && (h_total_w[TW-1:CW] == '0)    && (v_vs_start_w[TW-1:CW] == '0)
              && (v_vs_end_w[TW-1:CW] == '0)   && (v_total_w[TW-1:CW] == '0)
              && (h_active != '0) && (h_sync != '0)
              && (v_active != '0) && (v_sync != '0);
   end

   logic          frame_end, take_cfg, go_run;
   logic [CW-1:0] h_nxt, v_nxt;
   logic [CW-1:0] ha_sel, hss_sel, hse_sel, va_sel, vss_sel, vse_sel;
   logic          de_d, hs_d, vs_d, fs_d;

   always_comb begin
      frame_end = (hpos == h_last_s) && (vpos == v_last_s);
      take_cfg  = (state == LOAD) || ((state == RUN) && frame_end && en);
      go_run    = take_cfg ? in_valid : ((state == RUN) && !frame_end);

      h_nxt = '0;
      v_nxt = '0;
      if ((state == RUN) && !frame_end) begin
         if (hpos == h_last_s) begin
            v_nxt = vpos + CW'(1);
         end else begin
            h_nxt = hpos + CW'(1);
            v_nxt = vpos;
         end
      end

      // On a (re)load the outputs for pixel (0,0) must already reflect the new timing.
      ha_sel  = take_cfg ? h_active                  : ha_s;
      hss_sel = take_cfg ? h_hs_start_w[CW-1:0]      : hss_s;
      hse_sel = take_cfg ? h_hs_end_w[CW-1:0]        : hse_s;
      va_sel  = take_cfg ? v_active                  : va_s;
      vss_sel = take_cfg ? v_vs_start_w[CW-1:0]      : vss_s;
      vse_sel = take_cfg ? v_vs_end_w[CW-1:0]        : vse_s;

      de_d = go_run && (h_nxt < ha_sel) && (v_nxt < va_sel);
      hs_d = go_run && (h_nxt >= hss_sel) && (h_nxt < hse_sel);
      vs_d = go_run && (v_nxt >= vss_sel) && (v_nxt < vse_sel);
      fs_d = go_run && (h_nxt == '0) && (v_nxt == '0);
   end

`ifdef SYNC_GEN_PATTERN_EN
   localparam int PW = CW + 3;

   // Bar k starts at ceil(k*h_active/8), so bar index = count of boundaries <= hpos.
   logic [CW-1:0] bnd_in [1:7];
   logic [CW-1:0] bnd_s  [1:7];
   logic [2:0]    bar;
   logic [23:0]   color, rgb_d;

   generate
      for (genvar gi = 1; gi < 8; gi++) begin : g_bnd
         assign bnd_in[gi] = CW'((PW'(gi) * PW'(h_active) + PW'(7)) >> 3);
      end
   endgenerate

   always_comb begin
      bar = '0;
      for (int k = 1; k < 8; k++) begin
         if (h_nxt >= (take_cfg ? bnd_in[k] : bnd_s[k])) begin
            bar = bar + 3'd1;
         end
      end
      case (bar)
         3'd0:    color = 24'hFFFFFF;
         3'd1:    color = 24'hFFFF00;
         3'd2:    color = 24'h00FFFF;
         3'd3:    color = 24'h00FF00;
         3'd4:    color = 24'hFF00FF;
         3'd5:    color = 24'hFF0000;
         3'd6:    color = 24'h0000FF;
         default: color = 24'h000000;
      endcase
      rgb_d = de_d ? color : 24'h000000;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         hpos        <= '0;
         vpos        <= '0;
         de          <= 1'b0;
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
         frame_start <= 1'b0;
         cfg_err     <= 1'b0;
         ha_s        <= '0;
         hss_s       <= '0;
         hse_s       <= '0;
         h_last_s    <= '0;
         va_s        <= '0;
         vss_s       <= '0;
         vse_s       <= '0;
         v_last_s    <= '0;
`ifdef SYNC_GEN_PATTERN_EN
         rgb         <= '0;
         for (int k = 1; k < 8; k++) bnd_s[k] <= '0;
`endif
      end else begin
         case (state)
            IDLE:    if (en) state <= LOAD;
            LOAD:    state <= in_valid ? RUN : IDLE;
            RUN:     if (frame_end) state <= (en && in_valid) ? RUN : IDLE;
            default: state <= IDLE;
         endcase

         if (take_cfg) begin
            cfg_err  <= !in_valid;
            ha_s     <= h_active;
            hss_s    <= h_hs_start_w[CW-1:0];
            hse_s    <= h_hs_end_w[CW-1:0];
            h_last_s <= h_last_in;
            va_s     <= v_active;
            vss_s    <= v_vs_start_w[CW-1:0];
            vse_s    <= v_vs_end_w[CW-1:0];
            v_last_s <= v_last_in;
`ifdef SYNC_GEN_PATTERN_EN
            for (int k = 1; k < 8; k++) bnd_s[k] <= bnd_in[k];
`endif
         end

         hpos        <= h_nxt;
         vpos        <= v_nxt;
         de          <= de_d;
         hsync       <= hs_d ? HSYNC_POL : ~HSYNC_POL;
         vsync       <= vs_d ? VSYNC_POL : ~VSYNC_POL;
         frame_start <= fs_d;
`ifdef SYNC_GEN_PATTERN_EN
         rgb         <= rgb_d;
`endif
      end
   end

endmodule
